// File: rtl/bank_cmd_sequencer.sv
// rtl/bank_cmd_sequencer.sv - turns one arbitrated request into a PRE/ACT/RD/WR command sequence
//
// Holds one request at a time and tracks a 16-entry open-row table indexed by {bg,ba}.
// It emits PRE and ACT as needed, then RD or WR, while spacing them by T_RP, T_RCD and T_CCD.
// All commands go out on a single registered command bus; cmd_valid pulses for one cycle per command.
//
// Build option: define AUTO_PRECHARGE_EN for the closed-page policy. In that mode every RD/WR
// carries cmd_ap=1 and closes the bank. Without it the block uses the open-page policy and cmd_ap is 0.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid / req_ready       request handshake (ready only in IDLE)
//   data_i, idx_i, row_i,
//   col_i, t_i, ba_i, bg_i      request fields (t_i: 1=write, 0=read)
//   cmd_valid, cmd_o            command strobe and opcode (000 NOP, 001 ACT, 010 PRE, 011 RD, 100 WR)
//   addr_o, ba_o, bg_o          row on ACT, zero-extended column on RD/WR, target bank/group
//   data_o, idx_o, cmd_ap       write data (WR), request index (RD/WR), auto-precharge flag
module bank_cmd_sequencer #(
    parameter int IDX   = 6,
    parameter int RA    = 16,
    parameter int CA    = 10,
    parameter int DQ    = 16,
    parameter int T_RP  = 4,
    parameter int T_RCD = 4,
    parameter int T_CCD = 2,
    parameter int TW    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [DQ-1:0]  data_i,
    input  logic [IDX-1:0] idx_i,
    input  logic [RA-1:0]  row_i,
    input  logic [CA-1:0]  col_i,
    input  logic           t_i,
    input  logic [1:0]     ba_i,
    input  logic [1:0]     bg_i,
    output logic           cmd_valid,
    output logic [2:0]     cmd_o,
    output logic [RA-1:0]  addr_o,
    output logic [1:0]     ba_o,
    output logic [1:0]     bg_o,
    output logic [DQ-1:0]  data_o,
    output logic [IDX-1:0] idx_o,
    output logic           cmd_ap
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DECODE   = 3'd1;
    localparam logic [2:0] S_PRE      = 3'd2;
    localparam logic [2:0] S_WAIT_RP  = 3'd3;
    localparam logic [2:0] S_ACT      = 3'd4;
    localparam logic [2:0] S_WAIT_RCD = 3'd5;
    localparam logic [2:0] S_COL      = 3'd6;
    localparam logic [2:0] S_WAIT_CCD = 3'd7;

    localparam logic [2:0] CMD_NOP = 3'b000;
    localparam logic [2:0] CMD_ACT = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_RD  = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;

`ifdef AUTO_PRECHARGE_EN
    // With a closed page, the post-column wait must also cover the implicit precharge.
    localparam bit AP_EN     = 1'b1;
    localparam int POST_WAIT = T_CCD + T_RP - 1;
`else
    localparam bit AP_EN     = 1'b0;
    localparam int POST_WAIT = T_CCD;
`endif

    // A wait of T cycles is one emit cycle followed by T-1 WAIT cycles, so the timer loads T-1.
    localparam logic [TW-1:0] RP_LOAD   = TW'(T_RP - 1);
    localparam logic [TW-1:0] RCD_LOAD  = TW'(T_RCD - 1);
    localparam logic [TW-1:0] POST_LOAD = TW'(POST_WAIT - 1);

    logic [2:0]     state, state_next;
    logic [TW-1:0]  timer, timer_next, timer_dec;
    logic           timer_last;

    // Holding register for the request currently being sequenced.
    logic [DQ-1:0]  h_data;
    logic [IDX-1:0] h_idx;
    logic [RA-1:0]  h_row;
    logic [CA-1:0]  h_col;
    logic           h_t;
    logic [1:0]     h_ba;
    logic [1:0]     h_bg;
    logic [3:0]     h_bank;

    // Open-row table, one entry per {bg,ba}.
    logic [15:0]    open_tab;
    logic [RA-1:0]  row_tab [16];

    logic           bank_open;
    logic           row_hit;

    assign req_ready = (state == S_IDLE);
    assign h_bank    = {h_bg, h_ba};
    assign bank_open = open_tab[h_bank];
    assign row_hit   = (row_tab[h_bank] == h_row);

    // Saturating decrement. The WAIT states leave when the count reaches 1, so the next cycle is the emit cycle.
    assign timer_dec  = (timer != '0) ? timer - TW'(1) : '0;
    assign timer_last = (timer <= TW'(1));

    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            S_IDLE: begin
                if (req_valid) state_next = S_DECODE;
            end
            S_DECODE: begin
                // Under the closed-page policy every bank is closed by its last RD/WR, so ACT is always first.
                if (AP_EN || !bank_open) state_next = S_ACT;
                else if (row_hit)        state_next = S_COL;
                else                     state_next = S_PRE;
            end
            S_PRE: begin
                if (T_RP == 1) begin
                    state_next = S_ACT;
                end else begin
                    timer_next = RP_LOAD;
                    state_next = S_WAIT_RP;
                end
            end
            S_WAIT_RP: begin
                timer_next = timer_dec;
                if (timer_last) state_next = S_ACT;
            end
            S_ACT: begin
                if (T_RCD == 1) begin
                    state_next = S_COL;
                end else begin
                    timer_next = RCD_LOAD;
                    state_next = S_WAIT_RCD;
                end
            end
            S_WAIT_RCD: begin
                timer_next = timer_dec;
                if (timer_last) state_next = S_COL;
            end
            S_COL: begin
                if (POST_WAIT == 1) begin
                    state_next = S_IDLE;
                end else begin
                    timer_next = POST_LOAD;
                    state_next = S_WAIT_CCD;
                end
            end
            S_WAIT_CCD: begin
                timer_next = timer_dec;
                if (timer_last) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            h_data    <= '0;
            h_idx     <= '0;
            h_row     <= '0;
            h_col     <= '0;
            h_t       <= 1'b0;
            h_ba      <= '0;
            h_bg      <= '0;
            open_tab  <= '0;
            for (int i = 0; i < 16; i++) row_tab[i] <= '0;
            cmd_valid <= 1'b0;
            cmd_o     <= CMD_NOP;
            addr_o    <= '0;
            ba_o      <= '0;
            bg_o      <= '0;
            data_o    <= '0;
            idx_o     <= '0;
            cmd_ap    <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;

            if (state == S_IDLE && req_valid) begin
                h_data <= data_i;
                h_idx  <= idx_i;
                h_row  <= row_i;
                h_col  <= col_i;
                h_t    <= t_i;
                h_ba   <= ba_i;
                h_bg   <= bg_i;
            end

            // The command is loaded on the way into its emit state, so it is visible in that state's cycle.
            cmd_valid <= 1'b0;
            cmd_o     <= CMD_NOP;
            addr_o    <= '0;
            ba_o      <= '0;
            bg_o      <= '0;
            data_o    <= '0;
            idx_o     <= '0;
            cmd_ap    <= 1'b0;
            case (state_next)
                S_PRE: begin
                    cmd_valid <= 1'b1;
                    cmd_o     <= CMD_PRE;
                    ba_o      <= h_ba;
                    bg_o      <= h_bg;
                end
                S_ACT: begin
                    cmd_valid <= 1'b1;
                    cmd_o     <= CMD_ACT;
                    addr_o    <= h_row;
                    ba_o      <= h_ba;
                    bg_o      <= h_bg;
                end
                S_COL: begin
                    cmd_valid <= 1'b1;
                    cmd_o     <= h_t ? CMD_WR : CMD_RD;
                    addr_o    <= RA'(h_col);
                    ba_o      <= h_ba;
                    bg_o      <= h_bg;
                    data_o    <= h_t ? h_data : '0;
                    idx_o     <= h_idx;
                    cmd_ap    <= AP_EN;
                end
                default: begin
                end
            endcase

            // Table entries change only in the cycle their command is on the bus.
            case (state)
                S_PRE: open_tab[h_bank] <= 1'b0;
                S_ACT: begin
                    open_tab[h_bank] <= 1'b1;
                    row_tab[h_bank]  <= h_row;
                end
                S_COL: if (AP_EN) open_tab[h_bank] <= 1'b0;
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bank_cmd_sequencer.sv
// tb/tb_bank_cmd_sequencer.sv - directed self-checking bench for bank_cmd_sequencer
module tb_bank_cmd_sequencer;

    localparam int IDX = 6;
    localparam int RA  = 16;
    localparam int CA  = 10;
    localparam int DQ  = 16;
`ifdef AUTO_PRECHARGE_EN
    localparam bit AP   = 1'b1;
    localparam int POST = 5;
`else
    localparam bit AP   = 1'b0;
    localparam int POST = 2;
`endif

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [DQ-1:0]  data_i;
    logic [IDX-1:0] idx_i;
    logic [RA-1:0]  row_i;
    logic [CA-1:0]  col_i;
    logic           t_i;
    logic [1:0]     ba_i;
    logic [1:0]     bg_i;
    logic           cmd_valid;
    logic [2:0]     cmd_o;
    logic [RA-1:0]  addr_o;
    logic [1:0]     ba_o;
    logic [1:0]     bg_o;
    logic [DQ-1:0]  data_o;
    logic [IDX-1:0] idx_o;
    logic           cmd_ap;

    int n_checks = 0;
    int n_pass   = 0;

    bank_cmd_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .data_i    (data_i),
        .idx_i     (idx_i),
        .row_i     (row_i),
        .col_i     (col_i),
        .t_i       (t_i),
        .ba_i      (ba_i),
        .bg_i      (bg_i),
        .cmd_valid (cmd_valid),
        .cmd_o     (cmd_o),
        .addr_o    (addr_o),
        .ba_o      (ba_o),
        .bg_o      (bg_o),
        .data_o    (data_o),
        .idx_o     (idx_o),
        .cmd_ap    (cmd_ap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one request in cycle N, then check every cycle N+1..N+ready_at.
    // pre_at/act_at/col_at are the hand-computed offsets of each command (-1 = none).
    // hold_k > 0 keeps req_valid high with scrambled fields until cycle N+hold_k.
    task automatic run_req(input string name, input logic [1:0] bg, input logic [1:0] ba,
                           input logic [RA-1:0] row, input logic [CA-1:0] col, input logic t,
                           input logic [DQ-1:0] data, input logic [IDX-1:0] idx,
                           input int pre_at, input int act_at, input int col_at, input int hold_k);
        int ready_at;
        int guard;
        logic exp_v;
        ready_at = col_at + POST;
        guard = 0;
        while (!req_ready && guard < 50) begin
            step();
            guard++;
        end
        check($sformatf("%s.ready_in", name), 32'(req_ready), 32'd1);
        bg_i = bg; ba_i = ba; row_i = row; col_i = col; t_i = t; data_i = data; idx_i = idx;
        req_valid = 1'b1;
        step();
        if (hold_k == 0) req_valid = 1'b0;
        bg_i = ~bg; ba_i = ~ba; row_i = ~row; col_i = ~col; t_i = ~t; data_i = ~data; idx_i = ~idx;
        for (int k = 1; k <= ready_at; k++) begin
            if (hold_k != 0 && k == hold_k) req_valid = 1'b0;
            exp_v = (k == pre_at) || (k == act_at) || (k == col_at);
            check($sformatf("%s.valid@%0d", name, k), 32'(cmd_valid), 32'(exp_v));
            if (k == pre_at) begin
                check($sformatf("%s.pre_cmd", name), 32'(cmd_o), 32'd2);
                check($sformatf("%s.pre_bank", name), 32'({bg_o, ba_o}), 32'({bg, ba}));
            end
            if (k == act_at) begin
                check($sformatf("%s.act_cmd", name), 32'(cmd_o), 32'd1);
                check($sformatf("%s.act_addr", name), 32'(addr_o), 32'(row));
                check($sformatf("%s.act_bank", name), 32'({bg_o, ba_o}), 32'({bg, ba}));
            end
            if (k == col_at) begin
                check($sformatf("%s.col_cmd", name), 32'(cmd_o), t ? 32'd4 : 32'd3);
                check($sformatf("%s.col_addr", name), 32'(addr_o), 32'(col));
                check($sformatf("%s.col_bank", name), 32'({bg_o, ba_o}), 32'({bg, ba}));
                check($sformatf("%s.col_idx", name), 32'(idx_o), 32'(idx));
                check($sformatf("%s.col_ap", name), 32'(cmd_ap), 32'(AP));
                if (t) check($sformatf("%s.col_data", name), 32'(data_o), 32'(data));
            end
            check($sformatf("%s.ready@%0d", name, k), 32'(req_ready), 32'(k >= ready_at));
            if (k < ready_at) step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0;
        data_i = '0; idx_i = '0; row_i = '0; col_i = '0; t_i = 1'b0; ba_i = '0; bg_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", 32'(cmd_valid), 32'd0);
        check("rst.cmd", 32'(cmd_o), 32'd0);
        rst_n = 1'b1;
        step();
        check("rel.ready", 32'(req_ready), 32'd1);
        check("rel.valid", 32'(cmd_valid), 32'd0);
        check("rel.cmd", 32'(cmd_o), 32'd0);
        check("rel.ap", 32'(cmd_ap), 32'd0);

        // Closed bank: ACT at +2, RD at +6.
        run_req("closed", 2'd1, 2'd2, 16'h0ABC, 10'h015, 1'b0, 16'h0000, 6'd5, -1, 2, 6, 0);
        // Same row again as a write: hit (or ACT+WR under closed page).
        if (AP) run_req("hit", 2'd1, 2'd2, 16'h0ABC, 10'h015, 1'b1, 16'hBEEF, 6'd6, -1, 2, 6, 0);
        else    run_req("hit", 2'd1, 2'd2, 16'h0ABC, 10'h015, 1'b1, 16'hBEEF, 6'd6, -1, -1, 2, 0);
        // Different row in the same bank: PRE +2, ACT +6, RD +10.
        if (AP) run_req("miss", 2'd1, 2'd2, 16'h0123, 10'h020, 1'b0, 16'h0000, 6'd7, -1, 2, 6, 0);
        else    run_req("miss", 2'd1, 2'd2, 16'h0123, 10'h020, 1'b0, 16'h0000, 6'd7, 2, 6, 10, 0);
        // Another bank opens without disturbing bg1/ba2.
        run_req("other", 2'd0, 2'd0, 16'h0055, 10'h003, 1'b1, 16'h1234, 6'd8, -1, 2, 6, 0);
        if (AP) run_req("hit2", 2'd1, 2'd2, 16'h0123, 10'h3FF, 1'b0, 16'h0000, 6'd9, -1, 2, 6, 0);
        else    run_req("hit2", 2'd1, 2'd2, 16'h0123, 10'h3FF, 1'b0, 16'h0000, 6'd9, -1, -1, 2, 0);
        // Back-pressure: req_valid stays high with different fields through WAIT_RCD.
        run_req("bp", 2'd3, 2'd3, 16'h0AAA, 10'h011, 1'b0, 16'h0000, 6'd10, -1, 2, 6, 7);

        // Reset in the middle of WAIT_RCD: no RD may follow.
        bg_i = 2'd2; ba_i = 2'd1; row_i = 16'h0BBB; col_i = 10'h007; t_i = 1'b0; idx_i = 6'd11;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("rstmid.act", 32'(cmd_o), 32'd1);
        step();
        step();
        check("rstmid.wait_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rstmid.valid", 32'(cmd_valid), 32'd0);
        check("rstmid.ready", 32'(req_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rstmid.quiet@%0d", k), 32'(cmd_valid), 32'd0);
            step();
        end
        // Table cleared: the previously open bg1/ba2 row 0x0123 now needs an ACT.
        run_req("cleared", 2'd1, 2'd2, 16'h0123, 10'h001, 1'b0, 16'h0000, 6'd12, -1, 2, 6, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
